mem_access_ctrl: RTL and testbench

Initiator-side controller that drives the instruction/data memory's fetch port, data read/write port and region-clear strobe. It sits between the core's fetch and load/store logic and the memory, and serialises fetch, load, store and clear requests into the memory's edge-timed protocol. Results come back as one-cycle valid/done pulses, and out-of-range addresses are flagged.

---
 rtl/mem_if_pkg.sv | 31 +++
 rtl/mem_access_ctrl_if.sv | 41 ++++
 rtl/mem_addr_check.sv | 13 +
 rtl/mem_access_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the memory access controller and its address checker.
package mem_if_pkg;
    localparam int DEPTH      = 30;
    localparam int PROT_LIMIT = 11;
    localparam int CLR_BASE   = 11;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE, F_WAIT, F_CAPT, L_WAIT, L_CAPT, S_WR, C_CLR
    } state_t;

    // Every controller output is registered; this is the whole registered output set.
    typedef struct packed {
        word_t read_pc;
        word_t rw_addr;
        word_t value;
        word_t instr_out;
        word_t load_data;
        logic  op2_en;
        logic  op2_rw;
        logic  clear;
        logic  ack;
        logic  busy;
        logic  instr_valid;
        logic  load_valid;
        logic  store_done;
        logic  clr_done;
        logic  addr_err;
    } ctrl_out_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/result signals and memory-side strobes of the memory access controller.
interface mem_access_ctrl_if;
    import mem_if_pkg::*;

    logic  FetchReq;
    word_t PCIn;
    logic  LsReq;
    logic  LsWrite;
    word_t LsAddr;
    word_t LsWData;
    logic  ClrReq;
    word_t Instr;
    word_t Data;
    word_t ReadPC;
    word_t RWAddr;
    word_t Value;
    logic  OP2En;
    logic  OP2RW;
    logic  Clear;
    logic  Ack;
    logic  Busy;
    word_t InstrOut;
    word_t LoadData;
    logic  InstrValid;
    logic  LoadValid;
    logic  StoreDone;
    logic  ClrDone;
    logic  AddrErr;

    modport master (
        input  FetchReq, PCIn, LsReq, LsWrite, LsAddr, LsWData, ClrReq, Instr, Data,
        output ReadPC, RWAddr, Value, OP2En, OP2RW, Clear, Ack, Busy, InstrOut, LoadData,
               InstrValid, LoadValid, StoreDone, ClrDone, AddrErr
    );

    modport slave (
        output FetchReq, PCIn, LsReq, LsWrite, LsAddr, LsWData, ClrReq, Instr, Data,
        input  ReadPC, RWAddr, Value, OP2En, OP2RW, Clear, Ack, Busy, InstrOut, LoadData,
               InstrValid, LoadValid, StoreDone, ClrDone, AddrErr
    );
endinterface

// File: rtl/mem_addr_check.sv
// Combinational legality check: out of range, or a store into the protected instruction region.
module mem_addr_check
    import mem_if_pkg::*;
#(
    parameter int DEPTH      = mem_if_pkg::DEPTH,
    parameter int PROT_LIMIT = mem_if_pkg::PROT_LIMIT
) (
    input  word_t addr,
    input  logic  is_store,
    output logic  err
);
    assign err = (addr >= word_t'(DEPTH)) || (is_store && (addr < word_t'(PROT_LIMIT)));
endmodule

// File: rtl/mem_access_ctrl.sv
// Serialises clear/load/store/fetch requests onto the memory's edge-timed ports.
// Results and completions come back as registered one-cycle pulses.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int DEPTH      = mem_if_pkg::DEPTH,
    parameter int PROT_LIMIT = mem_if_pkg::PROT_LIMIT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    mem_access_ctrl_if.master bus
);
    state_t    state_q, state_d;
    ctrl_out_t out_q, out_d;
    word_t     chk_addr;
    logic      chk_store;
    logic      chk_err;

    // Clear carries no address, so the checker only sees the load/store or fetch candidate.
    assign chk_addr  = bus.LsReq ? bus.LsAddr : bus.PCIn;
    assign chk_store = bus.LsReq & bus.LsWrite;

    mem_addr_check #(.DEPTH(DEPTH), .PROT_LIMIT(PROT_LIMIT)) u_chk (
        .addr     (chk_addr),
        .is_store (chk_store),
        .err      (chk_err)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ClrReq)
                    state_d = C_CLR;
                else if (bus.LsReq) begin
                    if (!chk_err) state_d = bus.LsWrite ? S_WR : L_WAIT;
                end else if (bus.FetchReq) begin
                    if (!chk_err) state_d = F_WAIT;
                end
            end
            F_WAIT:  state_d = F_CAPT;
            L_WAIT:  state_d = L_CAPT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d             = out_q;
        out_d.ack         = 1'b0;
        out_d.instr_valid = 1'b0;
        out_d.load_valid  = 1'b0;
        out_d.store_done  = 1'b0;
        out_d.clr_done    = 1'b0;
        out_d.addr_err    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ClrReq) begin
                    out_d.ack   = 1'b1;
                    out_d.busy  = 1'b1;
                    out_d.clear = 1'b1;
                end else if (bus.LsReq || bus.FetchReq) begin
                    out_d.ack = 1'b1;
                    // A rejected request is acknowledged but never reaches the memory.
                    if (chk_err)
                        out_d.addr_err = 1'b1;
                    else if (bus.LsReq) begin
                        out_d.busy    = 1'b1;
                        out_d.rw_addr = bus.LsAddr;
                        out_d.op2_en  = 1'b1;
                        out_d.op2_rw  = bus.LsWrite;
                        if (bus.LsWrite) out_d.value = bus.LsWData;
                    end else begin
                        out_d.busy    = 1'b1;
                        out_d.read_pc = bus.PCIn;
                    end
                end
            end
            F_CAPT: begin
                out_d.instr_out   = bus.Instr;
                out_d.instr_valid = 1'b1;
                out_d.busy        = 1'b0;
            end
            L_WAIT: out_d.op2_en = 1'b0;
            L_CAPT: begin
                out_d.load_data  = bus.Data;
                out_d.load_valid = 1'b1;
                out_d.busy       = 1'b0;
            end
            S_WR: begin
                out_d.op2_en     = 1'b0;
                out_d.op2_rw     = 1'b0;
                out_d.store_done = 1'b1;
                out_d.busy       = 1'b0;
            end
            C_CLR: begin
                out_d.clear    = 1'b0;
                out_d.clr_done = 1'b1;
                out_d.busy     = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.ReadPC     = out_q.read_pc;
    assign bus.RWAddr     = out_q.rw_addr;
    assign bus.Value      = out_q.value;
    assign bus.InstrOut   = out_q.instr_out;
    assign bus.LoadData   = out_q.load_data;
    assign bus.OP2En      = out_q.op2_en;
    assign bus.OP2RW      = out_q.op2_rw;
    assign bus.Clear      = out_q.clear;
    assign bus.Ack        = out_q.ack;
    assign bus.Busy       = out_q.busy;
    assign bus.InstrValid = out_q.instr_valid;
    assign bus.LoadValid  = out_q.load_valid;
    assign bus.StoreDone  = out_q.store_done;
    assign bus.ClrDone    = out_q.clr_done;
    assign bus.AddrErr    = out_q.addr_err;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: memory model, transaction-level reference, per-cycle compare.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    import mem_if_pkg::*;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b1;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic word_t init_word(input int i);
        return (i == 5) ? 32'h00A0_0013 : (32'h1000_0000 + word_t'(i));
    endfunction

    // Memory: reads sampled on the rising edge, writes and clear on the falling edge.
    word_t mem [DEPTH];
    logic  mem_ready = 1'b0;

    always @(posedge Clk) begin
        bus.Instr <= (bus.ReadPC < word_t'(DEPTH)) ? mem[bus.ReadPC[4:0]] : '0;
        if (bus.OP2En && !bus.OP2RW && (bus.RWAddr < word_t'(DEPTH)))
            bus.Data <= mem[bus.RWAddr[4:0]];
    end

    always @(negedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else begin
            if (bus.OP2En && bus.OP2RW && (bus.RWAddr < word_t'(DEPTH)))
                mem[bus.RWAddr[4:0]] <= bus.Value;
            if (bus.Clear)
                for (int i = CLR_BASE; i < DEPTH; i++) mem[i] <= '0;
        end
    end

    // Reference: an accepted op completes a fixed number of edges later; strobes last one cycle.
    word_t ref_mem [DEPTH];
    int    cyc  = 0;
    int    pend = 0;
    int    kind = 0;
    word_t pval = '0;
    word_t e_pc = '0, e_rw = '0, e_val = '0, e_ins = '0, e_ld = '0;
    logic  e_en = 0, e_rwb = 0, e_clr = 0, e_ack = 0, e_busy = 0;
    logic  e_iv = 0, e_lv = 0, e_sd = 0, e_cd = 0, e_ae = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) begin
                pend = 0;
                e_pc = '0; e_rw = '0; e_val = '0; e_ins = '0; e_ld = '0;
                e_en = 0; e_rwb = 0; e_clr = 0; e_ack = 0; e_busy = 0;
                e_iv = 0; e_lv = 0; e_sd = 0; e_cd = 0; e_ae = 0;
            end else begin
                cyc++;
                e_ack = 0; e_iv = 0; e_lv = 0; e_sd = 0; e_cd = 0; e_ae = 0;
                e_en = 0; e_rwb = 0; e_clr = 0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        e_busy = 0;
                        case (kind)
                            0: begin e_ins = pval; e_iv = 1; end
                            1: begin e_ld = pval;  e_lv = 1; end
                            2: e_sd = 1;
                            default: e_cd = 1;
                        endcase
                    end
                end else if (bus.ClrReq) begin
                    e_ack = 1; e_busy = 1; e_clr = 1; kind = 3; pend = 1;
                    for (int i = CLR_BASE; i < DEPTH; i++) ref_mem[i] = '0;
                end else if (bus.LsReq) begin
                    e_ack = 1;
                    if ((bus.LsAddr >= word_t'(DEPTH)) || (bus.LsWrite && (bus.LsAddr < word_t'(PROT_LIMIT))))
                        e_ae = 1;
                    else if (bus.LsWrite) begin
                        e_busy = 1; e_en = 1; e_rwb = 1; e_rw = bus.LsAddr; e_val = bus.LsWData;
                        ref_mem[bus.LsAddr[4:0]] = bus.LsWData;
                        kind = 2; pend = 1;
                    end else begin
                        e_busy = 1; e_en = 1; e_rw = bus.LsAddr;
                        pval = ref_mem[bus.LsAddr[4:0]];
                        kind = 1; pend = 2;
                    end
                end else if (bus.FetchReq) begin
                    e_ack = 1;
                    if (bus.PCIn >= word_t'(DEPTH))
                        e_ae = 1;
                    else begin
                        e_busy = 1; e_pc = bus.PCIn;
                        pval = ref_mem[bus.PCIn[4:0]];
                        kind = 0; pend = 2;
                    end
                end
            end
        end
    end

    int checks = 0, errors = 0;
    int t_ack = 0, t_iv = 0, t_lv = 0, t_sd = 0, t_cd = 0, t_ae = 0;
    int busy_cnt = 0, op2_cnt = 0, lv_cnt = 0, ae_cnt = 0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Acts as the core: raise requests, drop each one on its Ack, then wait for the op to finish.
    task automatic issue(input logic c, input logic l, input logic w, input word_t la,
                         input word_t wd, input logic f, input word_t pc);
        int n;
        bus.ClrReq = c; bus.LsReq = l; bus.LsWrite = w; bus.LsAddr = la;
        bus.LsWData = wd; bus.FetchReq = f; bus.PCIn = pc;
        n = 0;
        while ((bus.ClrReq || bus.LsReq || bus.FetchReq) && (n < 40)) begin
            tick();
            n++;
            if (bus.Ack) begin
                if (bus.ClrReq)     bus.ClrReq = 1'b0;
                else if (bus.LsReq) bus.LsReq = 1'b0;
                else                bus.FetchReq = 1'b0;
            end
        end
        if (bus.ClrReq || bus.LsReq || bus.FetchReq) begin
            checks++; errors++;
            $display("FAIL ack_timeout: requests still pending after %0d cycles", n);
            bus.ClrReq = 1'b0; bus.LsReq = 1'b0; bus.FetchReq = 1'b0;
        end
        n = 0;
        while (bus.Busy && (n < 10)) begin
            tick();
            n++;
        end
        if (bus.Busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: Busy still 1 after %0d cycles", n);
        end
        tick();
    endtask

    word_t ld_addr [6] = '{32'd10, 32'd11, 32'd20, 32'd25, 32'd29, 32'd5};
    word_t ld_exp  [6] = '{32'h1000_000A, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 32'h00A0_0013};

    initial begin
        int n;
        int lv_before;
        bus.FetchReq = 0; bus.PCIn = '0; bus.LsReq = 0; bus.LsWrite = 0;
        bus.LsAddr = '0; bus.LsWData = '0; bus.ClrReq = 0;

        fork
            forever begin
                @(negedge Clk);
                checks++;
                if ({bus.ReadPC, bus.RWAddr, bus.Value, bus.InstrOut, bus.LoadData,
                     bus.OP2En, bus.OP2RW, bus.Clear, bus.Ack, bus.Busy,
                     bus.InstrValid, bus.LoadValid, bus.StoreDone, bus.ClrDone, bus.AddrErr} !==
                    {e_pc, e_rw, e_val, e_ins, e_ld, e_en, e_rwb, e_clr, e_ack, e_busy,
                     e_iv, e_lv, e_sd, e_cd, e_ae}) begin
                    errors++;
                    $display("FAIL outputs cyc %0d: got pc=%h rw=%h val=%h ins=%h ld=%h flags=%b expected pc=%h rw=%h val=%h ins=%h ld=%h flags=%b",
                             cyc, bus.ReadPC, bus.RWAddr, bus.Value, bus.InstrOut, bus.LoadData,
                             {bus.OP2En, bus.OP2RW, bus.Clear, bus.Ack, bus.Busy, bus.InstrValid,
                              bus.LoadValid, bus.StoreDone, bus.ClrDone, bus.AddrErr},
                             e_pc, e_rw, e_val, e_ins, e_ld,
                             {e_en, e_rwb, e_clr, e_ack, e_busy, e_iv, e_lv, e_sd, e_cd, e_ae});
                end
                if (bus.Ack)        t_ack = cyc;
                if (bus.InstrValid) t_iv = cyc;
                if (bus.LoadValid)  begin t_lv = cyc; lv_cnt++; end
                if (bus.StoreDone)  t_sd = cyc;
                if (bus.ClrDone)    t_cd = cyc;
                if (bus.AddrErr)    begin t_ae = cyc; ae_cnt++; end
                if (bus.Busy)       busy_cnt++;
                if (bus.OP2En)      op2_cnt++;
            end
        join_none

        #2 Rst_n = 1'b0;
        repeat (3) tick();
        Rst_n = 1'b1;
        chk("rst_readpc", bus.ReadPC, 32'h0);
        chk("rst_busy", {31'b0, bus.Busy}, 32'h0);
        tick();

        busy_cnt = 0;
        issue(0, 0, 0, 0, 0, 1, 32'd5);
        chk("fetch_instr", bus.InstrOut, 32'h00A0_0013);
        chk("fetch_latency", word_t'(t_iv - t_ack), 32'd2);
        chk("fetch_busy_cycles", word_t'(busy_cnt), 32'd2);

        issue(0, 1, 1, 32'd20, 32'hDEAD_BEEF, 0, 0);
        chk("store_latency", word_t'(t_sd - t_ack), 32'd1);
        issue(0, 1, 0, 32'd20, 0, 0, 0);
        chk("load_data", bus.LoadData, 32'hDEAD_BEEF);
        chk("load_latency", word_t'(t_lv - t_ack), 32'd2);

        op2_cnt = 0; ae_cnt = 0;
        issue(0, 1, 1, 32'd3, 32'hBAD0_BAD0, 0, 0);
        chk("store3_err", word_t'(ae_cnt), 32'd1);
        chk("store3_err_with_ack", word_t'(t_ae - t_ack), 32'd0);
        issue(0, 1, 0, 32'd30, 0, 0, 0);
        chk("load30_err", word_t'(ae_cnt), 32'd2);
        issue(0, 0, 0, 0, 0, 1, 32'd40);
        chk("fetch40_err", word_t'(ae_cnt), 32'd3);
        chk("err_no_op2en", word_t'(op2_cnt), 32'd0);
        chk("err_loaddata_held", bus.LoadData, 32'hDEAD_BEEF);
        chk("err_instrout_held", bus.InstrOut, 32'h00A0_0013);
        issue(0, 1, 0, 32'd3, 0, 0, 0);
        chk("word3_unchanged", bus.LoadData, 32'h1000_0003);

        issue(1, 1, 1, 32'd25, 32'h1234_5678, 1, 32'd5);
        chk("prio_clear_before_store", {31'b0, t_cd < t_sd}, 32'd1);
        chk("prio_store_before_fetch", {31'b0, t_sd < t_iv}, 32'd1);
        chk("prio_fetch_instr", bus.InstrOut, 32'h00A0_0013);
        for (int i = 0; i < 6; i++) begin
            issue(0, 1, 0, ld_addr[i], 0, 0, 0);
            chk($sformatf("post_clear_load_%0d", ld_addr[i]), bus.LoadData, ld_exp[i]);
        end

        bus.LsReq = 1'b1; bus.LsWrite = 1'b0; bus.LsAddr = 32'd25;
        n = 0;
        do begin tick(); n++; end while (!bus.Ack && (n < 20));
        bus.LsReq = 1'b0;
        chk("rst_test_ack", {31'b0, bus.Ack}, 32'd1);
        lv_before = lv_cnt;
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_async_busy", {31'b0, bus.Busy}, 32'h0);
        chk("rst_async_op2en", {31'b0, bus.OP2En}, 32'h0);
        chk("rst_async_rwaddr", bus.RWAddr, 32'h0);
        chk("rst_async_loaddata", bus.LoadData, 32'h0);
        repeat (2) tick();
        Rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_no_loadvalid", word_t'(lv_cnt - lv_before), 32'd0);
        issue(0, 0, 0, 0, 0, 1, 32'd7);
        chk("post_rst_fetch", bus.InstrOut, 32'h1000_0007);

        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
